// File: rtl/collatz_range_browser.sv
// collatz_range_browser
//   Board-level control between pushbuttons/switches and a Collatz "range"
//   engine. Debounces the keys, launches a run from the switch value, waits
//   for the engine with a watchdog, then lets the user browse the per-n
//   iteration counts with up/down/home keys (with hold-to-auto-repeat).
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   key_n[3:0]  raw active-low buttons: [3] go, [2] home/clear, [1] up, [0] down
//   sw          start value n
//   eng_go      one-cycle run pulse to the engine
//   eng_start   engine start value (LAUNCH/RUN) or result index (BROWSE)
//   eng_done    engine completion pulse
//   eng_count   engine iteration count for the current index
//   disp_n      n to display
//   disp_count  iteration count to display
//   busy        high while launching/running
//   error       high after a run timed out
module collatz_range_browser #(
  parameter int N_BITS          = 12,
  parameter int COUNT_BITS      = 16,
  parameter int RANGE_WORDS     = 256,
  parameter int ADDR_BITS       = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int READ_LAT        = 1,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int WRAP            = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            key_n,
  input  logic [N_BITS-1:0]     sw,
  output logic                  eng_go,
  output logic [31:0]           eng_start,
  input  logic                  eng_done,
  input  logic [COUNT_BITS-1:0] eng_count,
  output logic [N_BITS-1:0]     disp_n,
  output logic [COUNT_BITS-1:0] disp_count,
  output logic                  busy,
  output logic                  error
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAT_W = $clog2(READ_LAT + 2);

  localparam logic [DB_W-1:0]      DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]     RD_MAX  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]     RR_MAX  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0]     LAT_MAX = LAT_W'(READ_LAT);
  localparam logic [ADDR_BITS-1:0] OFF_MAX = ADDR_BITS'(RANGE_WORDS - 1);

  // ---------------------------------------------------------------------
  // Key path: 2-flop synchroniser (stored active-high), debouncer, edge
  // detector, and auto-repeat on the up/down keys.
  // ---------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] key_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            prev_q;
    logic            press;

    // The counter only runs while the synced sample disagrees with the
    // debounced level; any agreeing sample restarts it.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync2_q[gi] != level_q) begin
        if (db_cnt_q == DB_MAX) begin
          level_d = sync2_q[gi];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
        prev_q   <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        prev_q   <= level_q;
      end
    end

    assign press = level_q & ~prev_q;

    if (gi < 2) begin : g_rpt
      logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
      logic             rpt_first_q, rpt_first_d;
      logic             rpt_fire;

      // Counting starts the cycle after the press edge, so a fire at
      // count == DELAY-1 lands exactly DELAY cycles after the press.
      // Releasing the key returns to the defaults, cancelling any repeat.
      always_comb begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_fire    = 1'b0;
        if (level_q && prev_q) begin
          rpt_first_d = rpt_first_q;
          rpt_cnt_d   = rpt_cnt_q + 1'b1;
          if (rpt_first_q && (rpt_cnt_q == RD_MAX)) begin
            rpt_fire    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else if (!rpt_first_q && (rpt_cnt_q == RR_MAX)) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
        end else begin
          rpt_cnt_q   <= rpt_cnt_d;
          rpt_first_q <= rpt_first_d;
        end
      end

      assign key_ev[gi] = press | rpt_fire;
    end else begin : g_norpt
      assign key_ev[gi] = press;
    end
  end

  // Fixed priority go > home > up > down; losers in the same cycle are dropped.
  logic ev_go, ev_home, ev_up, ev_dn;
  assign ev_go   = key_ev[3];
  assign ev_home = key_ev[2] & ~key_ev[3];
  assign ev_up   = key_ev[1] & ~(key_ev[3] | key_ev[2]);
  assign ev_dn   = key_ev[0] & ~(key_ev[3] | key_ev[2] | key_ev[1]);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_BROWSE,
    S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [N_BITS-1:0]      base_q, base_d;
  logic [ADDR_BITS-1:0]   offset_q, offset_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [LAT_W-1:0]       settle_q, settle_d;

  logic                   eng_go_q, eng_go_d;
  logic [31:0]            eng_start_q, eng_start_d;
  logic [N_BITS-1:0]      disp_n_q, disp_n_d;
  logic [COUNT_BITS-1:0]  disp_count_q, disp_count_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (ev_go) begin
          base_d  = sw;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done takes precedence over a watchdog expiry in the same cycle
        if (eng_done) begin
          offset_d = '0;
          state_d  = S_BROWSE;
        end else if (wd_q == WD_MAX) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_BROWSE: begin
        if (ev_go) begin
          base_d  = sw;
          state_d = S_LAUNCH;
        end else if (ev_home) begin
          offset_d = '0;
        end else if (ev_up) begin
          if (offset_q == OFF_MAX) begin
            offset_d = (WRAP != 0) ? '0 : offset_q;
          end else begin
            offset_d = offset_q + 1'b1;
          end
        end else if (ev_dn) begin
          if (offset_q == '0) begin
            offset_d = (WRAP != 0) ? OFF_MAX : offset_q;
          end else begin
            offset_d = offset_q - 1'b1;
          end
        end
      end
      S_ERROR: begin
        if (ev_go) begin
          base_d  = sw;
          state_d = S_LAUNCH;
        end else if (ev_home) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // and clear immediately with the asynchronous reset.
  always_comb begin
    eng_go_d     = (state_d == S_LAUNCH);
    busy_d       = (state_d == S_LAUNCH) || (state_d == S_RUN);
    error_d      = (state_d == S_ERROR);
    eng_start_d  = 32'(base_d);
    disp_n_d     = base_d;
    disp_count_d = '0;

    // settle_q counts cycles since eng_start last moved to a new index; the
    // engine count is trusted once READ_LAT cycles have elapsed.
    settle_d = settle_q;
    if ((state_d == S_BROWSE) && ((state_q != S_BROWSE) || (offset_d != offset_q))) begin
      settle_d = '0;
    end else if (settle_q != LAT_MAX) begin
      settle_d = settle_q + 1'b1;
    end

    case (state_d)
      S_IDLE: begin
        eng_start_d = 32'(sw);
        disp_n_d    = sw;
      end
      S_BROWSE: begin
        eng_start_d = 32'(offset_d);
        // Truncated sum; the carry out of base+offset is deliberately dropped.
        disp_n_d    = base_d + N_BITS'(offset_d);
        if ((state_q == S_BROWSE) && (settle_q == LAT_MAX)) begin
          disp_count_d = eng_count;
        end else begin
          disp_count_d = disp_count_q;
        end
      end
      S_ERROR: begin
        disp_count_d = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      offset_q     <= '0;
      wd_q         <= '0;
      settle_q     <= '0;
      eng_go_q     <= 1'b0;
      eng_start_q  <= '0;
      disp_n_q     <= '0;
      disp_count_q <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      wd_q         <= wd_d;
      settle_q     <= settle_d;
      eng_go_q     <= eng_go_d;
      eng_start_q  <= eng_start_d;
      disp_n_q     <= disp_n_d;
      disp_count_q <= disp_count_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign eng_go     = eng_go_q;
  assign eng_start  = eng_start_q;
  assign disp_n     = disp_n_q;
  assign disp_count = disp_count_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_collatz_range_browser.sv
// Testbench for collatz_range_browser. Two instances share clock, reset and
// switches: dut_a saturates the browse offset, dut_w wraps it. Each has its
// own keys and a small engine model (done 30 cycles after eng_go, counts
// returned one cycle after eng_start).
module tb_collatz_range_browser;

  localparam logic [1:0] INST_A = 2'b01;
  localparam logic [1:0] INST_W = 2'b10;
  localparam logic [1:0] INST_B = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_a_n, key_w_n;
  logic [11:0] sw;

  logic        eng_go_a, eng_go_w;
  logic [31:0] eng_start_a, eng_start_w;
  logic        eng_done_a = 1'b0, eng_done_w = 1'b0;
  logic [15:0] eng_count_a = '0, eng_count_w = '0;
  logic [11:0] disp_n_a, disp_n_w;
  logic [15:0] disp_count_a, disp_count_w;
  logic        busy_a, busy_w, error_a, error_w;

  logic        hang_a = 1'b0, hang_w = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  collatz_range_browser #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .TIMEOUT_CYCLES(100),
    .RANGE_WORDS(8), .ADDR_BITS(3), .READ_LAT(1), .WRAP(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .key_n(key_a_n), .sw(sw),
    .eng_go(eng_go_a), .eng_start(eng_start_a), .eng_done(eng_done_a),
    .eng_count(eng_count_a), .disp_n(disp_n_a), .disp_count(disp_count_a),
    .busy(busy_a), .error(error_a)
  );

  collatz_range_browser #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .TIMEOUT_CYCLES(100),
    .RANGE_WORDS(8), .ADDR_BITS(3), .READ_LAT(1), .WRAP(1)
  ) dut_w (
    .clk(clk), .reset_n(reset_n), .key_n(key_w_n), .sw(sw),
    .eng_go(eng_go_w), .eng_start(eng_start_w), .eng_done(eng_done_w),
    .eng_count(eng_count_w), .disp_n(disp_n_w), .disp_count(disp_count_w),
    .busy(busy_w), .error(error_w)
  );

  function automatic int collatz_steps(input int unsigned n);
    longint v;
    int     s;
    v = longint'(n);
    s = 0;
    for (int i = 0; i < 2000 && v > 1; i++) begin
      if ((v % 2) != 0) v = 3 * v + 1;
      else              v = v / 2;
      s++;
    end
    return s;
  endfunction

  // Engine models
  int unsigned run_base_a = 0, run_base_w = 0;
  int          done_cnt_a = 0, done_cnt_w = 0;
  int          done_pulses_a = 0;

  always @(posedge clk) begin
    eng_done_a <= 1'b0;
    if (eng_go_a) begin
      run_base_a <= eng_start_a;
      done_cnt_a <= 30;
    end else if (done_cnt_a > 0) begin
      done_cnt_a <= done_cnt_a - 1;
      if (done_cnt_a == 1 && !hang_a) begin
        eng_done_a    <= 1'b1;
        done_pulses_a <= done_pulses_a + 1;
      end
    end
    eng_count_a <= 16'(collatz_steps(run_base_a + eng_start_a));
  end

  always @(posedge clk) begin
    eng_done_w <= 1'b0;
    if (eng_go_w) begin
      run_base_w <= eng_start_w;
      done_cnt_w <= 30;
    end else if (done_cnt_w > 0) begin
      done_cnt_w <= done_cnt_w - 1;
      if (done_cnt_w == 1 && !hang_w) eng_done_w <= 1'b1;
    end
    eng_count_w <= 16'(collatz_steps(run_base_w + eng_start_w));
  end

  // eng_go pulse monitors
  int          go_cnt_a = 0, go_cnt_w = 0;
  logic [31:0] go_start_a = '0;

  always @(negedge clk) begin
    if (eng_go_a) begin
      go_cnt_a   <= go_cnt_a + 1;
      go_start_a <= eng_start_a;
    end
    if (eng_go_w) go_cnt_w <= go_cnt_w + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_down(input logic [3:0] keys, input logic [1:0] inst);
    if (inst[0]) key_a_n = key_a_n & ~keys;
    if (inst[1]) key_w_n = key_w_n & ~keys;
  endtask

  task automatic key_up(input logic [1:0] inst);
    if (inst[0]) key_a_n = 4'hF;
    if (inst[1]) key_w_n = 4'hF;
  endtask

  // One clean press: 10 cycles held (no auto-repeat), 10 cycles released.
  task automatic press(input logic [3:0] keys, input logic [1:0] inst);
    key_down(keys, inst);
    repeat (10) tick();
    key_up(inst);
    repeat (10) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int pulses_before;

    reset_n = 1'b0;
    key_a_n = 4'hF;
    key_w_n = 4'hF;
    sw      = 12'd27;
    repeat (3) tick();

    // Reset state
    check_eq("rst_eng_go",     eng_go_a,     0);
    check_eq("rst_eng_start",  eng_start_a,  0);
    check_eq("rst_disp_n",     disp_n_a,     0);
    check_eq("rst_disp_count", disp_count_a, 0);
    check_eq("rst_busy",       busy_a,       0);
    check_eq("rst_error",      error_a,      0);

    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_disp_n",    disp_n_a,    27);
    check_eq("idle_eng_start", eng_start_a, 27);

    // 1. Launch both from sw=27, engine done after 30 cycles
    press(4'b1000, INST_B);
    for (n = 0; n < 100 && (busy_a || busy_w); n++) tick();
    check_eq("t1_run_ends",     (n < 100), 1);
    check_eq("t1_go_pulses",    go_cnt_a,  1);
    check_eq("t1_go_pulses_w",  go_cnt_w,  1);
    check_eq("t1_go_start",     go_start_a, 27);
    check_eq("t1_disp_n",       disp_n_a,  27);
    check_eq("t1_eng_start",    eng_start_a, 0);
    tick();
    tick();
    check_eq("t1_disp_count",   disp_count_a, 111);
    check_eq("t1_disp_count_w", disp_count_w, 111);

    // 2. Browse on the saturating instance
    repeat (3) press(4'b0010, INST_A);
    press(4'b0001, INST_A);
    check_eq("t2_eng_start",  eng_start_a,  2);
    check_eq("t2_disp_n",     disp_n_a,     29);
    check_eq("t2_disp_count", disp_count_a, 18);
    press(4'b0100, INST_A);
    check_eq("t2_home",       eng_start_a,  0);
    repeat (5) press(4'b0001, INST_A);
    check_eq("t2_sat_low",    eng_start_a,  0);
    check_eq("t2_sat_disp_n", disp_n_a,     27);

    // 3. Wrapping instance: down wraps to 7, up wraps to 0, then auto-repeat
    press(4'b0001, INST_W);
    check_eq("t3_wrap_dn",     eng_start_w, 7);
    check_eq("t3_wrap_dn_n",   disp_n_w,    34);
    press(4'b0010, INST_W);
    check_eq("t3_wrap_up",     eng_start_w, 0);
    check_eq("t3_wrap_up_n",   disp_n_w,    27);
    key_down(4'b0010, INST_W);
    repeat (40) tick();
    key_up(INST_W);
    repeat (10) tick();
    check_eq("t3_repeat_off",   eng_start_w,  5);
    check_eq("t3_repeat_n",     disp_n_w,     32);
    check_eq("t3_repeat_count", disp_count_w, 5);

    // 4. Glitch rejection and same-cycle priority
    repeat (2) press(4'b0010, INST_A);
    check_eq("t4_pre_off",   eng_start_a, 2);
    key_down(4'b0010, INST_A);
    repeat (3) tick();
    key_up(INST_A);
    repeat (10) tick();
    check_eq("t4_glitch",    eng_start_a, 2);
    press(4'b0110, INST_A);
    check_eq("t4_priority",  eng_start_a, 0);
    check_eq("t4_prio_n",    disp_n_a,    27);

    // 5. Engine hangs -> watchdog error after 100 RUN cycles
    hang_a = 1'b1;
    sw     = 12'd100;
    key_down(4'b1000, INST_A);
    for (n = 0; n < 20 && !busy_a; n++) tick();
    check_eq("t5_launched", busy_a, 1);
    key_up(INST_A);
    for (n = 0; n < 300 && busy_a; n++) tick();
    check_eq("t5_busy_cycles", n,            101);
    check_eq("t5_error",       error_a,      1);
    check_eq("t5_disp_count",  disp_count_a, 16'hFFFF);
    check_eq("t5_disp_n",      disp_n_a,     100);
    sw = 12'd55;
    press(4'b0100, INST_A);
    check_eq("t5_clear_error", error_a,  0);
    check_eq("t5_idle_disp_n", disp_n_a, 55);

    // 6. Reset in the middle of a run; the late done must be ignored
    hang_a = 1'b0;
    key_down(4'b1000, INST_A);
    for (n = 0; n < 20 && !busy_a; n++) tick();
    check_eq("t6_launched", busy_a, 1);
    key_up(INST_A);
    repeat (15) tick();
    pulses_before = done_pulses_a;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_eng_go",     eng_go_a,     0);
    check_eq("t6_rst_busy",       busy_a,       0);
    check_eq("t6_rst_disp_n",     disp_n_a,     0);
    check_eq("t6_rst_disp_count", disp_count_a, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    sw      = 12'd60;
    repeat (40) tick();
    check_eq("t6_late_done_seen", done_pulses_a, pulses_before + 1);
    check_eq("t6_idle_busy",      busy_a,        0);
    check_eq("t6_idle_disp_n",    disp_n_a,      60);
    check_eq("t6_idle_eng_start", eng_start_a,   60);
    check_eq("t6_idle_count",     disp_count_a,  0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
